video_pll_lock_ctrl: RTL and testbench
======================================

Name: video_pll_lock_ctrl

Overview:
- Controls the video rPLL's RESET pin and consumes its LOCK output. The PLL generates 74.25 MHz from 27 MHz for 720p60.
- Runs on the free-running 27 MHz input clock, so it keeps operating when the PLL output is absent.
- Pulses the PLL reset, waits for a lock that stays stable, then releases the video-domain reset.
- Handles lock loss and lock timeout by re-resetting the PLL, and keeps a loss counter for debug and UDP status reporting.

Parameters:
- RST_PULSE_CYCLES, 32: length of the pll_reset pulse, in clk cycles.
- LOCK_TIMEOUT_CYCLES, 270000: maximum cycles in WAIT_LOCK before the PLL is re-reset (10 ms at 27 MHz).
- STABLE_CYCLES, 2700: consecutive synchronised-lock-high cycles required before release (100 us).
- SYNC_STAGES, 2: flip-flop stages in the pll_lock synchroniser, minimum 2.
- MAX_RETRIES, 4: consecutive timeouts allowed before FAIL. Used only with PLL_RETRY_LIMIT_EN.

Ports:
- clk, input, 1: 27 MHz reference clock, the same net that feeds the PLL CLKIN.
- rst_n, input, 1: asynchronous, active-low reset.
- pll_lock, input, 1: rPLL LOCK, asynchronous to clk.
- pll_reset, output, 1: drives rPLL RESET, active-high.
- video_rst_n, output, 1: active-low reset for the video domain. The video domain re-synchronises its deassertion.
- locked, output, 1: high only in the RUN state.
- state, output, 2: current FSM state encoding, for debug.
- loss_count, output, 8: number of lock losses seen in RUN, saturating.
- pll_fail, output, 1: retry limit exhausted. Tied to 0 when the feature is compiled out.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values while rst_n is low:
  - state = PLL_RST, pll_reset = 1, video_rst_n = 0, locked = 0.
  - loss_count = 0, pll_fail = 0.
  - All counters = 0; all synchroniser flops = 0.
- Output timing: all outputs are registered, with no combinational path from any input.
- Lock synchronisation: pll_lock passes through a SYNC_STAGES flip-flop chain to produce lock_s. A pll_lock edge appears on lock_s SYNC_STAGES cycles later.
- Counters: one shared down/up counter, wide enough for max(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES). It is cleared on every state transition.
- State encoding: PLL_RST = 0, WAIT_LOCK = 1, STABLE = 2, RUN = 3. FAIL reuses encoding 0 and is distinguished by pll_fail = 1.
- PLL_RST:
  - pll_reset = 1, video_rst_n = 0.
  - After RST_PULSE_CYCLES cycles in this state, go to WAIT_LOCK; pll_reset falls on that transition.
  - lock_s is ignored in this state.
- WAIT_LOCK:
  - pll_reset = 0.
  - lock_s = 1 goes to STABLE.
  - If the count reaches LOCK_TIMEOUT_CYCLES-1 with lock_s = 0, go to PLL_RST; this counts as a timeout.
  - If lock_s rises on the same cycle as the timeout, lock wins and the FSM goes to STABLE.
- STABLE:
  - lock_s = 0 returns to WAIT_LOCK with a fresh timeout count. This does not increment loss_count.
  - After STABLE_CYCLES consecutive high cycles, go to RUN.
- RUN:
  - video_rst_n = 1 and locked = 1, both registered on the entry cycle.
  - lock_s = 0 causes, on the next clock:
    - video_rst_n = 0 and locked = 0;
    - loss_count increments, saturating at 255;
    - state goes to WAIT_LOCK.
  - The PLL is not reset on lock loss; reset happens only via the WAIT_LOCK timeout.
- Glitch handling: a lock glitch shorter than one clk period may be missed. This is acceptable.
- Mid-operation reset: rst_n asserted in any state returns all outputs to their reset values immediately (asynchronously). On release, the FSM restarts from PLL_RST.

Optional Feature:
- Macro: PLL_RETRY_LIMIT_EN.
- When defined:
  - A 3-bit retry counter increments on each WAIT_LOCK timeout and clears on entry to RUN.
  - When MAX_RETRIES timeouts have occurred, the next timeout goes to FAIL instead of PLL_RST.
  - FAIL holds pll_reset = 1, video_rst_n = 0 and pll_fail = 1 until rst_n is asserted.
- When not defined:
  - Timeouts retry indefinitely.
  - pll_fail is constant 0 and no retry counter is synthesised.

Test Plan (bench parameters: RST_PULSE_CYCLES = 4, LOCK_TIMEOUT_CYCLES = 50, STABLE_CYCLES = 10, MAX_RETRIES = 2):
1. Release rst_n, then raise pll_lock 8 cycles after pll_reset falls -> pll_reset high for exactly 4 cycles; video_rst_n rises 2 + 10 (+1 registering) cycles after the pll_lock edge; locked = 1; state = 3.
2. In STABLE, drop pll_lock after 5 cycles, then re-raise it -> video_rst_n stays 0, loss_count stays 0, and the full 10-cycle stable count restarts.
3. In RUN, drop pll_lock for 3 cycles, repeated 3 times -> video_rst_n falls 3 cycles after each drop (2 sync + 1 registered); loss_count = 3; pll_reset never asserts.
4. Hold pll_lock = 0 -> pll_reset pulses for 4 cycles every 54 cycles. Without the macro this continues indefinitely; with PLL_RETRY_LIMIT_EN, pll_fail = 1 after the 3rd timeout and pll_reset stays high.
5. Force 260 lock losses in RUN -> loss_count saturates at 255 and does not wrap to 0.
6. Assert rst_n while in RUN with loss_count = 7 -> video_rst_n = 0, locked = 0, loss_count = 0 and pll_reset = 1 within the same cycle, with no clock edge required.

Source files
------------

// File: rtl/video_pll_lock_ctrl.sv
// -----------------------------------------------------------------------------
// video_pll_lock_ctrl
//
// Supervises the video rPLL (27 MHz -> 74.25 MHz for 720p60). It pulses the
// PLL RESET pin and waits for LOCK to stay high for a qualifying period. It
// then releases the video-domain reset. If lock is lost, the video domain is
// put back in reset and the controller waits for lock again. If lock never
// arrives, the PLL is reset again. Lock losses seen in RUN are counted for
// debug and status reporting.
// The controller runs on the free-running reference clock, so it keeps working
// while the PLL output is absent.
//
// Optional build macro: PLL_RETRY_LIMIT_EN
//   When defined, consecutive lock timeouts are counted. Once MAX_RETRIES
//   timeouts have occurred, the next timeout parks the controller in FAIL,
//   with pll_fail = 1, until rst_n is asserted.
//   When undefined, timeouts retry forever and pll_fail is tied to 0.
//
// Ports:
//   clk          in   27 MHz reference (same net as PLL CLKIN)
//   rst_n        in   asynchronous active-low reset
//   pll_lock     in   rPLL LOCK, asynchronous to clk
//   pll_reset    out  rPLL RESET, active-high
//   video_rst_n  out  video-domain reset, active-low (re-synchronised downstream)
//   locked       out  high only in RUN
//   state        out  FSM state: 0 PLL_RST/FAIL, 1 WAIT_LOCK, 2 STABLE, 3 RUN
//   loss_count   out  lock losses seen in RUN, saturating at 255
//   pll_fail     out  retry limit exhausted (0 when the feature is compiled out)
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module video_pll_lock_ctrl #(
    parameter int RST_PULSE_CYCLES    = 32,
    parameter int LOCK_TIMEOUT_CYCLES = 270000,
    parameter int STABLE_CYCLES       = 2700,
    parameter int SYNC_STAGES         = 2,
    parameter int MAX_RETRIES         = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       video_rst_n,
    output logic       locked,
    output logic [1:0] state,
    output logic [7:0] loss_count,
    output logic       pll_fail
);

    // Shared counter sized for the longest interval it has to time.
    localparam int MAX_AB  = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                             RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_CNT = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    generate
        if (SYNC_STAGES < 2 || MAX_RETRIES < 0 || MAX_RETRIES > 7) begin : g_param_check
            $error("video_pll_lock_ctrl: SYNC_STAGES must be >= 2 and MAX_RETRIES within 0..7");
        end
    endgenerate

    // FAIL shares the external encoding 0 with PLL_RST. Bit 2 keeps it a
    // distinct internal state, and only bits [1:0] are exported.
    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0]   sync_q, sync_d;
    logic                     pll_reset_q, pll_reset_d;
    logic                     video_rst_n_q, video_rst_n_d;
    logic                     locked_q, locked_d;
    logic [7:0]               loss_count_q, loss_count_d;
    logic                     lock_s;

    // Lock synchroniser: pll_lock shifts in at bit 0.
    assign sync_d[0] = pll_lock;
    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            assign sync_d[gi] = sync_q[gi-1];
        end
    endgenerate
    assign lock_s = sync_q[SYNC_STAGES-1];

`ifdef PLL_RETRY_LIMIT_EN
    localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRIES);
    logic [2:0] retry_q, retry_d;
    logic       pll_fail_q, pll_fail_d;
    logic       timeout_hit;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        loss_count_d = loss_count_q;
`ifdef PLL_RETRY_LIMIT_EN
        timeout_hit  = 1'b0;
`endif
        case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock is checked first, so a lock arriving on the timeout
                // cycle wins.
                if (lock_s) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
`ifdef PLL_RETRY_LIMIT_EN
                    timeout_hit = 1'b1;
                    state_d     = (retry_q >= RETRY_MAX) ? ST_FAIL : ST_PLL_RST;
`else
                    state_d     = ST_PLL_RST;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RUN: begin
                // Lock loss only drops the video reset and re-waits. The PLL
                // is re-reset only if the lock then times out.
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    if (loss_count_q != 8'hFF) begin
                        loss_count_d = loss_count_q + 8'd1;
                    end
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_PLL_RST;
            end
        endcase

        // Each interval starts from zero.
        if (state_d != state_q) begin
            cnt_d = '0;
        end

        // Outputs are decoded from the next state, so they are registered
        // together with the state that owns them.
        pll_reset_d   = (state_d == ST_PLL_RST) || (state_d == ST_FAIL);
        video_rst_n_d = (state_d == ST_RUN);
        locked_d      = (state_d == ST_RUN);
    end

`ifdef PLL_RETRY_LIMIT_EN
    always_comb begin
        retry_d = retry_q;
        if (state_d == ST_RUN) begin
            retry_d = 3'd0;
        end else if (timeout_hit && retry_q != 3'd7) begin
            retry_d = retry_q + 3'd1;
        end
        pll_fail_d = (state_d == ST_FAIL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retry_q    <= 3'd0;
            pll_fail_q <= 1'b0;
        end else begin
            retry_q    <= retry_d;
            pll_fail_q <= pll_fail_d;
        end
    end

    assign pll_fail = pll_fail_q;
`else
    assign pll_fail = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q        <= '0;
            state_q       <= ST_PLL_RST;
            cnt_q         <= '0;
            pll_reset_q   <= 1'b1;
            video_rst_n_q <= 1'b0;
            locked_q      <= 1'b0;
            loss_count_q  <= 8'd0;
        end else begin
            sync_q        <= sync_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pll_reset_q   <= pll_reset_d;
            video_rst_n_q <= video_rst_n_d;
            locked_q      <= locked_d;
            loss_count_q  <= loss_count_d;
        end
    end

    assign pll_reset   = pll_reset_q;
    assign video_rst_n = video_rst_n_q;
    assign locked      = locked_q;
    assign state       = state_q[1:0];
    assign loss_count  = loss_count_q;

endmodule

// File: tb/tb_video_pll_lock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_video_pll_lock_ctrl
//
// Directed bench for video_pll_lock_ctrl with short intervals:
// reset pulse 4, timeout 50, stable 10, 2 sync stages, 2 retries.
// Inputs change 1 time unit after the rising edge.
// Outputs are sampled at that same point.
// Honours PLL_RETRY_LIMIT_EN for the retry-limit expectations.
// -----------------------------------------------------------------------------
module tb_video_pll_lock_ctrl;

    logic       clk;
    logic       rst_n;
    logic       pll_lock;
    logic       pll_reset;
    logic       video_rst_n;
    logic       locked;
    logic [1:0] state;
    logic [7:0] loss_count;
    logic       pll_fail;

    int checks = 0;
    int errors = 0;
    logic pll_reset_seen = 1'b0;

    localparam int SEL_STATE = 0;
    localparam int SEL_VRST  = 1;
    localparam int SEL_PRST  = 2;

    video_pll_lock_ctrl #(
        .RST_PULSE_CYCLES    (4),
        .LOCK_TIMEOUT_CYCLES (50),
        .STABLE_CYCLES       (10),
        .SYNC_STAGES         (2),
        .MAX_RETRIES         (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pll_lock    (pll_lock),
        .pll_reset   (pll_reset),
        .video_rst_n (video_rst_n),
        .locked      (locked),
        .state       (state),
        .loss_count  (loss_count),
        .pll_fail    (pll_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        pll_reset_seen = pll_reset_seen | pll_reset;
    endtask

    function automatic logic [7:0] sig_value(input int sel);
        case (sel)
            SEL_STATE: return {6'd0, state};
            SEL_VRST:  return {7'd0, video_rst_n};
            default:   return {7'd0, pll_reset};
        endcase
    endfunction

    // Ticks until the selected output equals val. n = edges taken. Bounded.
    task automatic wait_sig(input string tag, input int sel, input logic [7:0] val,
                            input int bound, output int n);
        n = 0;
        while (sig_value(sel) !== val && n < bound) begin
            tick();
            n++;
        end
        if (sig_value(sel) !== val) begin
            check({tag, "_timeout"}, {24'd0, sig_value(sel)}, {24'd0, val});
        end
    endtask

    // Drops lock for 3 input cycles, then restores it and waits for RUN.
    task automatic lose_and_recover(output int fall_lat);
        int n;
        pll_lock = 1'b0;
        fall_lat = 0;
        while (video_rst_n === 1'b1 && fall_lat < 20) begin
            tick();
            fall_lat++;
        end
        n = fall_lat;
        while (n < 3) begin
            tick();
            n++;
        end
        pll_lock = 1'b1;
        wait_sig("recover", SEL_VRST, 8'd1, 100, n);
    endtask

    initial begin
        int n;
        int lat;

        // ---- Reset values ----
        rst_n    = 1'b0;
        pll_lock = 1'b0;
        tick(); tick(); tick();
        check("rst_state",       {30'd0, state},      32'd0);
        check("rst_pll_reset",   {31'd0, pll_reset},  32'd1);
        check("rst_video_rst_n", {31'd0, video_rst_n}, 32'd0);
        check("rst_locked",      {31'd0, locked},     32'd0);
        check("rst_loss_count",  {24'd0, loss_count}, 32'd0);
        check("rst_pll_fail",    {31'd0, pll_fail},   32'd0);
        $display("step reset: state=%0d pll_reset=%0d", state, pll_reset);

        // ---- 1: lock-up from reset ----
        rst_n = 1'b1;
        wait_sig("t1_pulse", SEL_PRST, 8'd0, 100, n);
        check("t1_pulse_len", n, 32'd4);
        check("t1_state_wait", {30'd0, state}, 32'd1);
        for (int i = 0; i < 8; i++) tick();
        pll_lock = 1'b1;
        wait_sig("t1_release", SEL_VRST, 8'd1, 100, n);
        check("t1_release_lat", n, 32'd13);
        check("t1_locked", {31'd0, locked}, 32'd1);
        check("t1_state_run", {30'd0, state}, 32'd3);
        $display("step 1: release latency=%0d", n);

        // ---- 3: three short lock losses in RUN ----
        pll_reset_seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            lose_and_recover(lat);
            check("t3_fall_lat", lat, 32'd3);
            $display("step 3: loss %0d fall latency=%0d loss_count=%0d", k, lat, loss_count);
        end
        check("t3_loss_count", {24'd0, loss_count}, 32'd3);
        check("t3_no_pll_reset", {31'd0, pll_reset_seen}, 32'd0);

        // ---- 2: lock drop while in STABLE ----
        pll_lock = 1'b0;
        wait_sig("t2_to_wait", SEL_STATE, 8'd1, 20, n);
        check("t2_run_to_wait", n, 32'd3);
        check("t2_loss_after_run_drop", {24'd0, loss_count}, 32'd4);
        pll_lock = 1'b1;
        wait_sig("t2_to_stable", SEL_STATE, 8'd2, 20, n);
        check("t2_wait_to_stable", n, 32'd3);
        tick(); tick(); tick();
        pll_lock = 1'b0;
        wait_sig("t2_stable_drop", SEL_STATE, 8'd1, 20, n);
        check("t2_stable_drop_lat", n, 32'd3);
        check("t2_vrst_held", {31'd0, video_rst_n}, 32'd0);
        check("t2_loss_held", {24'd0, loss_count}, 32'd4);
        pll_lock = 1'b1;
        wait_sig("t2_to_stable2", SEL_STATE, 8'd2, 20, n);
        wait_sig("t2_release", SEL_VRST, 8'd1, 100, n);
        check("t2_full_stable_count", n, 32'd10);
        check("t2_loss_final", {24'd0, loss_count}, 32'd4);
        $display("step 2: stable restart count=%0d", n);

        // ---- 4: lock held low -> repeated PLL resets ----
        pll_lock = 1'b0;
        wait_sig("t4_to_wait", SEL_STATE, 8'd1, 20, n);
        check("t4_loss", {24'd0, loss_count}, 32'd5);
        for (int k = 0; k < 2; k++) begin
            wait_sig("t4_rise", SEL_PRST, 8'd1, 200, n);
            check("t4_timeout_gap", n, 32'd50);
            wait_sig("t4_fall", SEL_PRST, 8'd0, 200, n);
            check("t4_pulse_len", n, 32'd4);
            $display("step 4: timeout %0d handled", k);
        end
        wait_sig("t4_rise3", SEL_PRST, 8'd1, 200, n);
        check("t4_timeout_gap3", n, 32'd50);
        check("t4_state_zero", {30'd0, state}, 32'd0);
`ifdef PLL_RETRY_LIMIT_EN
        check("t4_pll_fail", {31'd0, pll_fail}, 32'd1);
        for (int i = 0; i < 20; i++) tick();
        check("t4_fail_hold_reset", {31'd0, pll_reset}, 32'd1);
        check("t4_fail_hold_flag", {31'd0, pll_fail}, 32'd1);
`else
        check("t4_pll_fail", {31'd0, pll_fail}, 32'd0);
        wait_sig("t4_fall3", SEL_PRST, 8'd0, 200, n);
        check("t4_pulse_len3", n, 32'd4);
`endif
        $display("step 4: third timeout pll_fail=%0d", pll_fail);

        // ---- 6: asynchronous reset while in RUN with loss_count = 7 ----
        rst_n = 1'b0;
        tick();
        pll_lock = 1'b1;
        tick();
        rst_n = 1'b1;
        wait_sig("t6_run", SEL_VRST, 8'd1, 200, n);
        for (int k = 0; k < 7; k++) lose_and_recover(lat);
        check("t6_loss_pre", {24'd0, loss_count}, 32'd7);
        check("t6_state_pre", {30'd0, state}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_vrst", {31'd0, video_rst_n}, 32'd0);
        check("t6_async_locked", {31'd0, locked}, 32'd0);
        check("t6_async_loss", {24'd0, loss_count}, 32'd0);
        check("t6_async_pll_reset", {31'd0, pll_reset}, 32'd1);
        check("t6_async_state", {30'd0, state}, 32'd0);
        $display("step 6: async reset loss_count=%0d pll_reset=%0d", loss_count, pll_reset);

        // ---- 5: loss counter saturation ----
        tick();
        rst_n = 1'b1;
        wait_sig("t5_run", SEL_VRST, 8'd1, 200, n);
        for (int k = 0; k < 254; k++) lose_and_recover(lat);
        check("t5_loss_254", {24'd0, loss_count}, 32'd254);
        lose_and_recover(lat);
        check("t5_loss_255", {24'd0, loss_count}, 32'd255);
        for (int k = 0; k < 5; k++) lose_and_recover(lat);
        check("t5_loss_saturated", {24'd0, loss_count}, 32'd255);
        check("t5_locked_again", {31'd0, locked}, 32'd1);
        $display("step 5: loss_count after 260 losses=%0d", loss_count);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
